// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions: opcode width and encodings, load funct3 encodings,
// and the writeback FSM state type.
package writeback_stage_pkg;

  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load lane select and sign/zero extension.
module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] funct3_i,
  input  logic [1:0]             byte_off_i,
  input  logic [DWIDTH-1:0]      load_data_i,
  output logic [DWIDTH-1:0]      ext_data_o
);

  logic [DWIDTH-1:0] byte_sh_s;
  logic [DWIDTH-1:0] half_sh_s;

  // Halfword lanes are aligned on byte_off[1]; byte_off[0] does not matter.
  assign byte_sh_s = load_data_i >> {byte_off_i, 3'b000};
  assign half_sh_s = load_data_i >> {byte_off_i[1], 4'b0000};

  always_comb begin
    ext_data_o = load_data_i;
    case (funct3_i)
      FUNCT_WIDTH'(F3_LB):  ext_data_o = {{(DWIDTH-8){byte_sh_s[7]}}, byte_sh_s[7:0]};
      FUNCT_WIDTH'(F3_LBU): ext_data_o = {{(DWIDTH-8){1'b0}}, byte_sh_s[7:0]};
      FUNCT_WIDTH'(F3_LH):  ext_data_o = {{(DWIDTH-16){half_sh_s[15]}}, half_sh_s[15:0]};
      FUNCT_WIDTH'(F3_LHU): ext_data_o = {{(DWIDTH-16){1'b0}}, half_sh_s[15:0]};
      FUNCT_WIDTH'(F3_LW):  ext_data_o = load_data_i;
      default:              ext_data_o = load_data_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: waits for load data, extends it, and issues one
// register-file write per instruction. WB_RETIRE_CNT_EN adds a retirement counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wb_i_ce,
  input  logic                    wb_i_stall,
  input  logic                    wb_i_flush,
  input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  wb_i_funct3,
  input  logic [1:0]              wb_i_byte_off,
  input  logic [AWIDTH-1:0]       wb_i_rd_addr,
  input  logic [DWIDTH-1:0]       wb_i_rd_data,
  input  logic                    wb_i_rd_we,
  input  logic                    wb_i_ack,
  input  logic [DWIDTH-1:0]       wb_i_load_data,
  output logic [AWIDTH-1:0]       wb_o_rd_addr,
  output logic [DWIDTH-1:0]       wb_o_rd_data,
  output logic                    wb_o_rd_we,
  output logic                    wb_o_stall,
  output logic                    wb_o_ce
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]             wb_o_retire_cnt
`endif
);

  wb_state_e              state_q, state_d;
  logic [AWIDTH-1:0]      pend_addr_q, pend_addr_d;
  logic [DWIDTH-1:0]      pend_data_q, pend_data_d;
  logic                   pend_we_q, pend_we_d;
  logic [FUNCT_WIDTH-1:0] pend_f3_q, pend_f3_d;
  logic [1:0]             pend_off_q, pend_off_d;
  logic                   stall_q;
  logic [AWIDTH-1:0]      last_addr_q;
  logic [DWIDTH-1:0]      last_data_q;

  logic [FUNCT_WIDTH-1:0] ext_f3_s;
  logic [1:0]             ext_off_s;
  logic [DWIDTH-1:0]      ext_data_s;
  logic                   fire_s;
  logic                   rd_we_s;

  // A same-cycle ack in IDLE extends with the live inputs, otherwise with the latched ones.
  assign ext_f3_s  = (state_q == ST_IDLE) ? wb_i_funct3   : pend_f3_q;
  assign ext_off_s = (state_q == ST_IDLE) ? wb_i_byte_off : pend_off_q;

  load_extend #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_load_extend (
    .funct3_i    (ext_f3_s),
    .byte_off_i  (ext_off_s),
    .load_data_i (wb_i_load_data),
    .ext_data_o  (ext_data_s)
  );

  // Next-state and pending-field capture.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_we_d   = pend_we_q;
    pend_f3_d   = pend_f3_q;
    pend_off_d  = pend_off_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_i_ce && is_load(wb_i_opcode)) begin
          pend_addr_d = wb_i_rd_addr;
          pend_we_d   = 1'b1;
          pend_f3_d   = wb_i_funct3;
          pend_off_d  = wb_i_byte_off;
          if (wb_i_ack) begin
            pend_data_d = ext_data_s;
            state_d     = ST_WRITE;
          end else begin
            state_d     = ST_WAIT_ACK;
          end
        end else if (wb_i_ce && !wb_i_stall) begin
          pend_addr_d = wb_i_rd_addr;
          pend_data_d = wb_i_rd_data;
          pend_we_d   = wb_i_rd_we;
          state_d     = ST_WRITE;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (wb_i_ack) begin
          pend_data_d = ext_data_s;
          state_d     = ST_WRITE;
        end else begin
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WRITE: begin
        if (!wb_i_stall) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wb_i_flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign fire_s  = (state_q == ST_WRITE) && !wb_i_stall && !wb_i_flush;
  assign rd_we_s = fire_s && pend_we_q && (pend_addr_q != {AWIDTH{1'b0}});

  // State, pending fields and last-written values.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= {AWIDTH{1'b0}};
      pend_data_q <= {DWIDTH{1'b0}};
      pend_we_q   <= 1'b0;
      pend_f3_q   <= {FUNCT_WIDTH{1'b0}};
      pend_off_q  <= 2'b00;
      stall_q     <= 1'b0;
      last_addr_q <= {AWIDTH{1'b0}};
      last_data_q <= {DWIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_we_q   <= pend_we_d;
      pend_f3_q   <= pend_f3_d;
      pend_off_q  <= pend_off_d;
      stall_q     <= (state_d == ST_WAIT_ACK);
      if (rd_we_s) begin
        last_addr_q <= pend_addr_q;
        last_data_q <= pend_data_q;
      end
    end
  end

  // Address/data only move on a real write so the register file sees stable values otherwise.
  assign wb_o_rd_addr = rd_we_s ? pend_addr_q : last_addr_q;
  assign wb_o_rd_data = rd_we_s ? pend_data_q : last_data_q;
  assign wb_o_rd_we   = rd_we_s;
  assign wb_o_ce      = fire_s;
  assign wb_o_stall   = stall_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // Retirement counter, wraps naturally.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      retire_cnt_q <= 32'd0;
    end else if (fire_s) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign wb_o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ce_i, stall_i, flush_i, rd_we_i, ack_i;
  logic [OPCODE_WIDTH-1:0] opcode_i;
  logic [2:0]              funct3_i;
  logic [1:0]              off_i;
  logic [4:0]              rd_addr_i;
  logic [31:0]             rd_data_i, load_data_i;
  logic [4:0]              rd_addr_o;
  logic [31:0]             rd_data_o;
  logic                    rd_we_o, stall_o, ce_o;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]             retire_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .wb_clk         (clk),
    .wb_rst         (rst),
    .wb_i_ce        (ce_i),
    .wb_i_stall     (stall_i),
    .wb_i_flush     (flush_i),
    .wb_i_opcode    (opcode_i),
    .wb_i_funct3    (funct3_i),
    .wb_i_byte_off  (off_i),
    .wb_i_rd_addr   (rd_addr_i),
    .wb_i_rd_data   (rd_data_i),
    .wb_i_rd_we     (rd_we_i),
    .wb_i_ack       (ack_i),
    .wb_i_load_data (load_data_i),
    .wb_o_rd_addr   (rd_addr_o),
    .wb_o_rd_data   (rd_data_o),
    .wb_o_rd_we     (rd_we_o),
    .wb_o_stall     (stall_o),
    .wb_o_ce        (ce_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .wb_o_retire_cnt(retire_cnt_o)
`endif
  );

  task automatic idle_inputs();
    ce_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; rd_we_i = 1'b0; ack_i = 1'b0;
    opcode_i = 7'd0; funct3_i = 3'd0; off_i = 2'd0;
    rd_addr_i = 5'd0; rd_data_i = 32'd0; load_data_i = 32'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rtype(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_RTYPE; rd_addr_i = a; rd_data_i = d; rd_we_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b ce=%b st=%b a=%0d d=%h, expected all 0",
               rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    drive_rtype(5'd3, 32'd12345);
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o} !== {3'b110, 5'd3, 32'd12345}) begin
      n_fail++;
      $display("FAIL rtype_write: got we=%b ce=%b st=%b a=%0d d=%0d, expected 1 1 0 3 12345",
               rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, rd_addr_o, rd_data_o} !== {2'b00, 5'd3, 32'd12345}) begin
      n_fail++;
      $display("FAIL rtype_hold: got we=%b ce=%b a=%0d d=%0d, expected 0 0 3 12345",
               rd_we_o, ce_o, rd_addr_o, rd_data_o);
    end
  endtask

  task automatic test_load_lb_late();
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_LB; off_i = 2'd1; rd_addr_i = 5'd5;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL lb_stall1: got we=%b ce=%b st=%b, expected 0 0 1", rd_we_o, ce_o, stall_o);
    end
    // A new instruction offered while waiting must be ignored.
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_RTYPE; rd_addr_i = 5'd10; rd_data_i = 32'h55; rd_we_i = 1'b1;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL lb_stall2: got we=%b ce=%b st=%b, expected 0 0 1", rd_we_o, ce_o, stall_o);
    end
    @(negedge clk);
    idle_inputs();
    ack_i = 1'b1; load_data_i = 32'h0000_8000;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o} !== {3'b110, 5'd5, 32'hFFFF_FF80}) begin
      n_fail++;
      $display("FAIL lb_write: got we=%b ce=%b st=%b a=%0d d=%h, expected 1 1 0 5 ffffff80",
               rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL lb_after: got we=%b ce=%b st=%b, expected 0 0 0", rd_we_o, ce_o, stall_o);
    end
  endtask

  task automatic test_load_lhu_same_cycle();
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_LHU; off_i = 2'd2; rd_addr_i = 5'd7;
    ack_i = 1'b1; load_data_i = 32'hBEEF_0000;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o} !== {3'b110, 5'd7, 32'h0000_BEEF}) begin
      n_fail++;
      $display("FAIL lhu_write: got we=%b ce=%b st=%b a=%0d d=%h, expected 1 1 0 7 0000beef",
               rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
  endtask

  task automatic test_rd_zero();
    drive_rtype(5'd0, 32'd7);
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, rd_addr_o, rd_data_o} !== {2'b01, 5'd7, 32'h0000_BEEF}) begin
      n_fail++;
      $display("FAIL rd_zero: got we=%b ce=%b a=%0d d=%h, expected 0 1 7 0000beef",
               rd_we_o, ce_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
  endtask

  task automatic test_write_stall();
    drive_rtype(5'd9, 32'hA5);
    @(posedge clk);
    #1;
    stall_i = 1'b1;
    #1;
    n_tests++;
    if ({rd_we_o, ce_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_stall1: got we=%b ce=%b, expected 0 0", rd_we_o, ce_o);
    end
    @(negedge clk);
    ce_i = 1'b0;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_stall2: got we=%b ce=%b, expected 0 0", rd_we_o, ce_o);
    end
    stall_i = 1'b0;
    #1;
    n_tests++;
    if ({rd_we_o, ce_o, rd_addr_o, rd_data_o} !== {2'b11, 5'd9, 32'hA5}) begin
      n_fail++;
      $display("FAIL write_release: got we=%b ce=%b a=%0d d=%h, expected 1 1 9 a5",
               rd_we_o, ce_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_single: got we=%b ce=%b, expected 0 0", rd_we_o, ce_o);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_LW; rd_addr_i = 5'd4;
    cyc();
    @(negedge clk);
    idle_inputs();
    flush_i = 1'b1; ack_i = 1'b1; load_data_i = 32'h1234_5678;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_ack: got we=%b ce=%b st=%b, expected 0 0 0", rd_we_o, ce_o, stall_o);
    end
    @(negedge clk);
    idle_inputs();
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_data_o} !== {3'b000, 32'hA5}) begin
      n_fail++;
      $display("FAIL flush_idle: got we=%b ce=%b st=%b d=%h, expected 0 0 0 a5",
               rd_we_o, ce_o, stall_o, rd_data_o);
    end
    // Flush beats a simultaneous ce in IDLE.
    drive_rtype(5'd6, 32'h66);
    flush_i = 1'b1;
    cyc();
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if ({rd_we_o, ce_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_ce: got we=%b ce=%b, expected 0 0", rd_we_o, ce_o);
    end
  endtask

  task automatic test_reset_wait_ack();
    @(negedge clk);
    idle_inputs();
    ce_i = 1'b1; opcode_i = OPC_LOAD; funct3_i = F3_LW; rd_addr_i = 5'd8;
    cyc();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; ack_i = 1'b1; load_data_i = 32'hCAFE_F00D;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_wait_ack: got we=%b ce=%b st=%b a=%0d d=%h, expected all 0",
               rd_we_o, ce_o, stall_o, rd_addr_o, rd_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    n_tests++;
    if ({rd_we_o, ce_o, stall_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_discard: got we=%b ce=%b st=%b, expected 0 0 0", rd_we_o, ce_o, stall_o);
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_rtype(5'd1, 32'(i));
      cyc();
      @(negedge clk);
      idle_inputs();
      cyc();
    end
    n_tests++;
    if (retire_cnt_o !== 32'd3) begin
      n_fail++;
      $display("FAIL retire_cnt3: got %0d expected 3", retire_cnt_o);
    end
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    drive_rtype(5'd2, 32'd1);
    cyc();
    @(negedge clk);
    idle_inputs();
    cyc();
    n_tests++;
    if (retire_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_wrap: got %h expected 0", retire_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_lb_late();
    test_load_lhu_same_cycle();
    test_rd_zero();
    test_write_stall();
    test_flush();
    test_reset_wait_ack();
`ifdef WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width.
REQ-002 SHALL have parameter AWIDTH, default 5, register-address width.
REQ-003 SHALL have parameter FUNCT_WIDTH, default 3, funct3 width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as follows.
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst  in  1  synchronous active-high reset.
- wb_i_ce  in  1  valid instruction from memory stage.
- wb_i_stall  in  1  downstream/hazard stall.
- wb_i_flush  in  1  kill in-flight instruction.
- wb_i_opcode  in  `OPCODE_WIDTH  opcode from memory stage.
- wb_i_funct3  in  FUNCT_WIDTH  load size/sign.
- wb_i_byte_off  in  2  load address bits [1:0].
- wb_i_rd_addr  in  AWIDTH  destination register.
- wb_i_rd_data  in  DWIDTH  non-load result.
- wb_i_rd_we  in  1  non-load write request.
- wb_i_ack  in  1  data-memory bus acknowledge.
- wb_i_load_data  in  DWIDTH  data-memory read word, valid with wb_i_ack.
- wb_o_rd_addr  out  AWIDTH  register-file write address.
- wb_o_rd_data  out  DWIDTH  register-file write data.
- wb_o_rd_we  out  1  register-file write strobe, one cycle per instruction.
- wb_o_stall  out  1  back-pressure to memory stage.
- wb_o_ce  out  1  instruction retired this cycle.

Function
REQ-005 SHALL implement FSM IDLE, WAIT_ACK, WRITE.
REQ-006 IDLE, wb_i_ce=1, wb_i_stall=0, opcode not `LOAD: SHALL latch rd_addr/rd_data/rd_we, go WRITE. Latency is 1 cycle.
REQ-007 IDLE, wb_i_ce=1, opcode `LOAD, wb_i_ack=1 in the same cycle: SHALL latch extended load data, go WRITE.
REQ-008 IDLE, wb_i_ce=1, opcode `LOAD, wb_i_ack=0: SHALL latch rd_addr/funct3/byte_off, go WAIT_ACK, assert wb_o_stall.
REQ-009 WAIT_ACK: wb_o_stall=1; on wb_i_ack=1 SHALL latch extended data, go WRITE. It waits with no timeout.
REQ-010 WRITE with wb_i_stall=0: SHALL pulse wb_o_rd_we and wb_o_ce for exactly one cycle, then return to IDLE. WRITE with wb_i_stall=1: SHALL hold state with wb_o_rd_we=0.
REQ-011 wb_o_rd_we SHALL be forced 0 when rd_addr==0. wb_o_ce still pulses.
REQ-012 Load extension rules:
- LB/LBU select byte lane byte_off.
- LH/LHU select half {byte_off[1],0}; byte_off[0] is ignored.
- LW passes the word.
- LB/LH sign-extend; LBU/LHU zero-extend.
- Undefined funct3 is treated as LW.
REQ-013 Loads always write (rd_we=1, subject to REQ-011). Non-loads use wb_i_rd_we.
REQ-014 wb_i_flush=1 in any state SHALL return to IDLE with no write. Flush takes priority over a simultaneous ack or ce.
REQ-015 wb_i_ce SHALL be ignored outside IDLE.
REQ-016 wb_o_rd_addr/wb_o_rd_data SHALL hold their last values when wb_o_rd_we=0.

Reset
REQ-017 wb_rst=1 SHALL force IDLE and zero all outputs and latched fields, including mid-WAIT_ACK. A pending ack is discarded.

Configuration
REQ-018 With WB_RETIRE_CNT_EN defined:
- Add output wb_o_retire_cnt, 32 bits.
- It increments on each wb_o_ce, wraps 0xFFFFFFFF->0, and resets to 0.
- Without the macro, the port and counter are absent.

Structure
REQ-019 `OPCODE_WIDTH, opcode constants (`LOAD, `RTYPE, ...) and funct3 load encodings SHALL live in the shared pipeline definitions package/header used by all stages.
REQ-020 Lane select and extension SHALL be a combinational sub-module load_extend.

Verification
REQ-021 The bench SHALL cover these scenarios:
- RTYPE, rd=3, data=12345, ce 1 cycle -> next cycle rd_we=1, rd_addr=3, rd_data=12345, ce=1.
- LOAD LB, off=1, ack 2 cycles late, load_data=0x0000_8000 -> stall 2 cycles, then rd_data=0xFFFF_FF80.
- LOAD LHU, off=2, same-cycle ack, load_data=0xBEEF_0000 -> rd_data=0x0000_BEEF, no stall.
- RTYPE rd=0, data=7 -> rd_we=0, ce=1.
- LOAD in WAIT_ACK, then flush and ack in the same cycle -> no write, IDLE next cycle; reset mid-WAIT_ACK -> all outputs 0.
- WB_RETIRE_CNT_EN: 3 retirements -> wb_o_retire_cnt=3; preset 0xFFFFFFFF plus 1 retire -> 0.
